// File: rtl/gameboy_fb_pkg.sv
// Shared types and constants for the Game Boy double-buffered framebuffer.
// The write-entry struct fixes the default frame-memory geometry (15-bit address, 2-bit pixel).
package gameboy_fb_pkg;

    localparam int LCD_WIDTH     = 160;
    localparam int LCD_HEIGHT    = 144;
    localparam int FB_PIXELS     = LCD_WIDTH * LCD_HEIGHT;
    localparam int FB_ADDR_WIDTH = 15;
    localparam int FB_DATA_WIDTH = 2;

    typedef struct packed {
        logic [FB_ADDR_WIDTH-1:0] addr;
        logic [FB_DATA_WIDTH-1:0] data;
        logic                     last;
    } fb_wr_entry_t;

    typedef enum logic [0:0] {
        WRITING = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/gameboy_fb_write_fifo.sv
// Small synchronous FIFO buffering decoder pixels ahead of the frame memory.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module gameboy_fb_write_fifo
    import gameboy_fb_pkg::*;
#(
    parameter type entry_t = fb_wr_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t           store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            store[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = store[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/gameboy_framebuffer_arbiter.sv
// Arbitrates the single-port double-buffered frame RAM between decoder writes and scanout reads,
// and swaps buffers only at reader frame start so the display never tears.
module gameboy_framebuffer_arbiter
    import gameboy_fb_pkg::*;
#(
    parameter int DATA_WIDTH   = 2,
    parameter int ADDR_WIDTH   = 15,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_frame_start,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  front_buffer,
    output logic [7:0]            drop_count
);

    localparam logic [0:0] ST_WRITING = WRITING;
    localparam logic [0:0] ST_PENDING = PENDING;
    localparam int         SW         = $clog2(STARVE_LIMIT + 1);

    fb_wr_entry_t  push_entry;
    fb_wr_entry_t  head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          write_pending;
    logic          write_forced;
    logic          write_grant;
    logic          read_grant;
    logic          swap_now;
    logic          front_eff;

    logic [0:0]    state;
    logic          front_q;
    logic [7:0]    drop_q;
    logic [SW-1:0] starve_cnt;
    logic          rdv_q;

    assign push_entry.addr = FB_ADDR_WIDTH'(wr_addr);
    assign push_entry.data = FB_DATA_WIDTH'(wr_data);
    assign push_entry.last = wr_last;

    assign wr_ready = reset && !fifo_full;
    assign push     = wr_valid && wr_ready;

    gameboy_fb_write_fifo #(
        .entry_t (fb_wr_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_write_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (write_grant),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Reads win by default; the writer is forced through once it has been denied STARVE_LIMIT times.
    assign write_pending = reset && !fifo_empty;
    assign write_forced  = (starve_cnt == SW'(STARVE_LIMIT));
    assign write_grant   = write_pending && (!rd_valid || write_forced);
    assign read_grant    = reset && rd_valid && !write_grant;

    // A swap seen this cycle already steers this cycle's accesses to the new front/back.
    assign swap_now  = reset && rd_frame_start && (state == ST_PENDING);
    assign front_eff = front_q ^ swap_now;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (write_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {~front_eff, ADDR_WIDTH'(head.addr)};
            mem_wdata = DATA_WIDTH'(head.data);
        end else if (read_grant) begin
            mem_en    = 1'b1;
            mem_addr  = {front_eff, rd_addr};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || write_grant) begin
            starve_cnt <= '0;
        end else if (!write_forced) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // A frame finishing while another is still waiting for display overwrites it: count the drop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_WRITING;
            front_q <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            front_q <= front_eff;
            if (write_grant) begin
                if (state == ST_PENDING && !swap_now) begin
                    drop_q <= sat_inc8(drop_q);
                end
                state <= head.last ? ST_PENDING : ST_WRITING;
            end else if (swap_now) begin
                state <= ST_WRITING;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdv_q <= 1'b0;
        end else begin
            rdv_q <= read_grant;
        end
    end

    assign rd_ready      = read_grant;
    assign rd_data       = mem_rdata;
    assign rd_data_valid = reset && rdv_q;
    assign front_buffer  = reset && front_q;
    assign drop_count    = reset ? drop_q : 8'd0;

endmodule

// File: tb/tb_gameboy_framebuffer_arbiter.sv
// Randomized bench for the framebuffer arbiter, checked against a queue-based reference model
// that drives a behavioural frame RAM and predicts every memory access and read result.
module tb_gameboy_framebuffer_arbiter;

    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 2;
    localparam int HALF         = 32768;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [1:0]  wr_data;
    logic        wr_last;
    logic        rd_valid;
    logic        rd_ready;
    logic [14:0] rd_addr;
    logic        rd_frame_start;
    logic [1:0]  rd_data;
    logic        rd_data_valid;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata;
    logic        front_buffer;
    logic [7:0]  drop_count;

    typedef struct {
        int addr;
        int data;
        bit last;
    } pix_t;

    pix_t   q[$];
    int     starve;
    bit     m_front;
    bit     m_pending;
    int     m_drops;
    bit     m_prev_read;
    int     m_read_data;
    int     model_mem [65536];
    logic [1:0] ram [65536];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    gameboy_framebuffer_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_last        (wr_last),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_addr        (rd_addr),
        .rd_frame_start (rd_frame_start),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .front_buffer   (front_buffer),
        .drop_count     (drop_count)
    );

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearModel();
        q.delete();
        starve      = 0;
        m_front     = 1'b0;
        m_pending   = 1'b0;
        m_drops     = 0;
        m_prev_read = 1'b0;
        m_read_data = 0;
    endtask

    // Called just after a rising edge; drives one cycle, checks, advances the model and the clock.
    task automatic applyStimulus(input bit wv, input int wa, input int wd, input bit wl,
                                 input bit rv, input int ra, input bit rfs);
        bit   w_go, r_go, swap, nf, can_push;
        int   waddr, raddr;
        pix_t hd;
        wr_valid       = wv;
        wr_addr        = 15'(wa);
        wr_data        = 2'(wd);
        wr_last        = wl;
        rd_valid       = rv;
        rd_addr        = 15'(ra);
        rd_frame_start = rfs;
        #2;
        can_push = (q.size() < FIFO_DEPTH);
        w_go     = (q.size() > 0) && (!rv || starve == STARVE_LIMIT);
        r_go     = rv && !w_go;
        swap     = m_pending && rfs;
        nf       = m_front ^ swap;
        raddr    = (nf ? HALF : 0) + ra;
        checkOutput("wr_ready", 32'(wr_ready), 32'(can_push));
        checkOutput("rd_ready", 32'(rd_ready), 32'(r_go));
        checkOutput("mem_en", 32'(mem_en), 32'(w_go || r_go));
        checkOutput("mem_we", 32'(mem_we), 32'(w_go));
        if (w_go) begin
            hd    = q[0];
            waddr = (nf ? 0 : HALF) + hd.addr;
            checkOutput("mem_addr_wr", 32'(mem_addr), 32'(waddr));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(hd.data));
        end else if (r_go) begin
            checkOutput("mem_addr_rd", 32'(mem_addr), 32'(raddr));
        end
        checkOutput("rd_data_valid", 32'(rd_data_valid), 32'(m_prev_read));
        if (m_prev_read) checkOutput("rd_data", 32'(rd_data), 32'(m_read_data));
        checkOutput("front_buffer", 32'(front_buffer), 32'(m_front));
        checkOutput("drop_count", 32'(drop_count), 32'(m_drops));

        m_prev_read = r_go;
        if (r_go) m_read_data = model_mem[raddr];
        if (q.size() == 0 || w_go) starve = 0;
        else if (rv) starve++;
        m_front = nf;
        if (swap) m_pending = 1'b0;
        if (w_go) begin
            hd = q.pop_front();
            model_mem[(nf ? 0 : HALF) + hd.addr] = hd.data;
            if (m_pending) begin
                if (m_drops < 255) m_drops++;
                m_pending = 1'b0;
            end
            if (hd.last) m_pending = 1'b1;
        end
        if (wv && can_push) q.push_back('{addr: wa, data: wd, last: wl});
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        reset          = 1'b0;
        wr_valid       = 1'($urandom_range(0, 1));
        wr_addr        = 15'($urandom_range(0, 15));
        wr_data        = 2'($urandom_range(0, 3));
        wr_last        = 1'($urandom_range(0, 1));
        rd_valid       = 1'($urandom_range(0, 1));
        rd_addr        = 15'($urandom_range(0, 15));
        rd_frame_start = 1'($urandom_range(0, 1));
        #2;
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'(0));
        checkOutput("rst_rd_ready", 32'(rd_ready), 32'(0));
        checkOutput("rst_rd_data_valid", 32'(rd_data_valid), 32'(0));
        checkOutput("rst_mem_en", 32'(mem_en), 32'(0));
        checkOutput("rst_mem_we", 32'(mem_we), 32'(0));
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        checkOutput("rst_front_buffer", 32'(front_buffer), 32'(0));
        checkOutput("rst_drop_count", 32'(drop_count), 32'(0));
        clearModel();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic randomCycle(input int rd_pct);
        applyStimulus($urandom_range(0, 9) < 6, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 99) < rd_pct,
                      int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]       = 2'd0;
            model_mem[i] = 0;
        end
        mem_rdata = 2'd0;
        clearModel();
        reset = 1'b0;
        @(posedge clock);
        #1;
        applyReset();
        applyReset();

        // idle after release, then a lone write of addr 5 / data 2 into the back buffer
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // continuous reads with four queued writes: writer gets every third slot
        for (int i = 0; i < 4; i++) applyStimulus(1, 8 + i, i, 0, 1, i, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 1, i, 0);

        // short frame ending with last, drained, then a frame start swaps to buffer 1
        for (int i = 0; i < 3; i++) applyStimulus(1, i, 3 - i, i == 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // finished frame never displayed: next frame's first write drops it
        applyStimulus(1, 3, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // pending frame, frame start coinciding with a write grant: swap first, no drop
        applyStimulus(1, 6, 3, 1, 0, 0, 0);
        applyStimulus(1, 7, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 7, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) randomCycle(70);
        for (int i = 0; i < 500; i++) randomCycle(100);
        applyReset();
        for (int i = 0; i < 1500; i++) randomCycle(50);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gameboy_framebuffer_arbiter.md
# gameboy_framebuffer_arbiter

Shares a single-port double-buffered frame memory between the LCD decoder (writer) and the display scanout (reader), and sequences buffer swaps. Decoder pixels pass through a 4-entry write FIFO into the back buffer while the reader fetches from the front buffer. Swaps occur only at reader frame start, so the display never tears. It sits between `gameboy_lcd_decoder` and the frame RAM.

## Interface
- DATA_WIDTH, 2, pixel width
- ADDR_WIDTH, 15, pixel address width within one buffer
- FIFO_DEPTH, 4, write FIFO entries (power of two)
- STARVE_LIMIT, 2, consecutive writer denials before the writer is forced a grant

- clock  in  1  sole clock
- reset  in  1  synchronous, active-low
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  FIFO not full; transfer on wr_valid&wr_ready
- wr_addr  in  ADDR_WIDTH  pixel address
- wr_data  in  DATA_WIDTH  pixel value
- wr_last  in  1  pixel is last of its frame
- rd_valid  in  1  reader requests a read
- rd_ready  out  1  read granted this cycle (combinational)
- rd_addr  in  ADDR_WIDTH  read address
- rd_frame_start  in  1  one-cycle pulse at reader frame start
- rd_data  out  DATA_WIDTH  read data (= mem_rdata)
- rd_data_valid  out  1  rd_data valid, one cycle after grant
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH+1  {buffer bit, pixel address}
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, 1-cycle latency
- front_buffer  out  1  buffer currently displayed
- drop_count  out  8  frames overwritten before display, saturating

## Operation
- Write FIFO: entry {addr, data, last}; push on wr_valid&wr_ready. Head pops when the writer is granted. wr_ready = !full. Simultaneous push and pop on a full FIFO is not allowed (wr_ready=0).
- Arbitration (one access per cycle): only rd_valid → read; only FIFO non-empty → write; both → read, unless starve_cnt == STARVE_LIMIT, then write. starve_cnt increments when the writer is pending and denied, and clears on a write grant or when the FIFO is empty.
- Read grant: mem_en=1, mem_we=0, mem_addr={front_buffer, rd_addr}, rd_ready=1.
- Write grant: mem_en=1, mem_we=1, mem_addr={~front_buffer, head.addr}, mem_wdata=head.data.
- No grant: mem_en=0, mem_we=0.
- Swap FSM, states WRITING and PENDING:
  - WRITING → PENDING when a head with last=1 is written to memory.
  - PENDING → WRITING with front_buffer toggled on rd_frame_start.
  - PENDING → WRITING without toggle on the first memory write of the next frame (pending frame dropped). drop_count increments, saturating at 255.
- Same cycle as rd_frame_start in PENDING plus a write grant: swap takes effect first. The write targets the new back buffer (the old front). No drop.
- rd_frame_start in WRITING: ignored.
- Read granted in the same cycle as a swap uses the new front_buffer.
- Reset mid-operation: FIFO flushed, in-flight rd_data_valid cleared, state WRITING, front_buffer=0. Partial frame contents in memory are left undefined.

## Timing
- While reset=0: wr_ready=0, rd_ready=0, rd_data_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, front_buffer=0, drop_count=0.
- First cycle after release: wr_ready=1.
- Write: pixel accepted at cycle t reaches memory at the earliest at t+1.
- Read: granted at t, rd_data_valid=1 at t+1 with rd_data=mem_rdata.
- Writer bandwidth is guaranteed at no less than 1 grant per STARVE_LIMIT+1 cycles under continuous reads.
- front_buffer and state change on the clock edge of the sampled rd_frame_start or last-write cycle.

## Structure
- Package gameboy_fb_pkg:
  - LCD_WIDTH=160, LCD_HEIGHT=144, FB_PIXELS=23040
  - write-entry struct {addr, data, last}
  - swap-state enum {WRITING, PENDING}
- Sub-module gameboy_fb_write_fifo: synchronous FIFO with push/pop/full/empty. Arbitration and swap FSM stay in the top.

## Test plan
- Reset release, idle → wr_ready=1, mem_en=0, front_buffer=0, drop_count=0.
- Write addr 5 data 2, no reads → next cycle mem_we=1, mem_addr=0x8005, mem_wdata=2.
- Continuous rd_valid plus 4 queued writes → write grants at every 3rd cycle. Reads use mem_addr MSB=0. rd_data_valid one cycle after each rd_ready.
- Full frame written ending wr_last, then rd_frame_start → front_buffer=1. Next read of addr 0 → mem_addr=0x8000.
- Frame completes, no rd_frame_start, next-frame write granted → front_buffer unchanged, drop_count=1.
- rd_frame_start in PENDING in the same cycle as a write grant → front_buffer toggles, write MSB = old front, drop_count unchanged.
